// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared writeback source indices and load funct3 encodings
package wb_pkg;

  localparam int SRC_MEM = 0;
  localparam int SRC_ALU = 1;
  localparam int SRC_PC4 = 2;
  localparam int SRC_IMM = 3;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - combinational load byte/half alignment, extension and misalign detect
module load_extend
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] word_i,
  input  logic [2:0]            funct3_i,
  input  logic [1:0]            addr_low_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  misalign_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_low_i)
      2'd0:    byte_sel = word_i[7:0];
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase
    half_sel = addr_low_i[1] ? word_i[31:16] : word_i[15:0];

    // Unknown funct3 codes pass the word through and never flag an error.
    data_o     = word_i;
    misalign_o = 1'b0;
    case (funct3_i)
      F3_LB:  data_o = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
      F3_LBU: data_o = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
      F3_LH: begin
        data_o     = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
        misalign_o = addr_low_i[0];
      end
      F3_LHU: begin
        data_o     = {{(DATA_WIDTH-16){1'b0}}, half_sel};
        misalign_o = addr_low_i[0];
      end
      F3_LW:   misalign_o = (addr_low_i != 2'b00);
      default: ;
    endcase
  end

endmodule

// File: rtl/wb_select_stage.sv
// rtl/wb_select_stage.sv - registered MEM/WB writeback source selector with load extension
module wb_select_stage
  import wb_pkg::*;
#(
  parameter  int DATA_WIDTH     = 32,
  parameter  int NUM_SRC        = 4,
  parameter  int REG_ADDR_WIDTH = 5,
  parameter  int LOAD_EXT       = 1,
  localparam int SEL_WIDTH      = $clog2(NUM_SRC)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          Stall,
  input  logic                          Flush,
  input  logic                          InValid,
  input  logic [SEL_WIDTH-1:0]          Sel,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] InData,
  input  logic [2:0]                    Funct3,
  input  logic [1:0]                    AddrLow,
  input  logic [REG_ADDR_WIDTH-1:0]     Rd,
  input  logic                          RegWrite,
  output logic                          OutValid,
  output logic [DATA_WIDTH-1:0]         OutData,
  output logic [REG_ADDR_WIDTH-1:0]     OutRd,
  output logic                          OutRegWrite,
  output logic                          MisalignErr
);

  if (LOAD_EXT == 1 && DATA_WIDTH < 32) begin : g_chk_width
    $error("wb_select_stage: DATA_WIDTH must be >= 32 when LOAD_EXT=1");
  end
  if (NUM_SRC < 2) begin : g_chk_src
    $error("wb_select_stage: NUM_SRC must be >= 2");
  end

  logic [DATA_WIDTH-1:0] src0;
  logic [DATA_WIDTH-1:0] ext_data;
  logic                  ext_mis;

  assign src0 = InData[DATA_WIDTH-1:0];

  if (LOAD_EXT != 0) begin : g_ext
    load_extend #(.DATA_WIDTH(DATA_WIDTH)) u_load_extend (
      .word_i     (src0),
      .funct3_i   (Funct3),
      .addr_low_i (AddrLow),
      .data_o     (ext_data),
      .misalign_o (ext_mis)
    );
  end else begin : g_raw
    assign ext_data = src0;
    assign ext_mis  = 1'b0;
  end

  logic                      is_mem;
  logic                      misalign;
  logic [DATA_WIDTH-1:0]     mux_data;
  logic                      valid_d,    valid_q;
  logic [DATA_WIDTH-1:0]     data_d,     data_q;
  logic [REG_ADDR_WIDTH-1:0] rd_d,       rd_q;
  logic                      regwrite_d, regwrite_q;
  logic                      mis_d,      mis_q;

  always_comb begin
    // Out-of-range selects fall through to zero.
    mux_data = '0;
    for (int k = 1; k < NUM_SRC; k++) begin
      if (Sel == SEL_WIDTH'(k)) mux_data = InData[k*DATA_WIDTH +: DATA_WIDTH];
    end
    is_mem = (Sel == SEL_WIDTH'(SRC_MEM));
    if (is_mem) mux_data = ext_data;

    misalign   = is_mem & InValid & ext_mis;
    valid_d    = InValid;
    data_d     = misalign ? '0 : mux_data;
    rd_d       = Rd;
    regwrite_d = InValid & RegWrite & (Rd != '0) & ~misalign;
    mis_d      = misalign;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      data_q     <= '0;
      rd_q       <= '0;
      regwrite_q <= 1'b0;
      mis_q      <= 1'b0;
    end else if (Flush) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      mis_q      <= 1'b0;
    end else if (!Stall) begin
      valid_q    <= valid_d;
      data_q     <= data_d;
      rd_q       <= rd_d;
      regwrite_q <= regwrite_d;
      mis_q      <= mis_d;
    end
  end

  assign OutValid    = valid_q;
  assign OutData     = data_q;
  assign OutRd       = rd_q;
  assign OutRegWrite = regwrite_q;
  assign MisalignErr = mis_q;

endmodule

// File: tb/tb_wb_select_stage.sv
// tb/tb_wb_select_stage.sv - table-driven scoreboard bench for wb_select_stage
module tb_wb_select_stage;

  logic        clk = 1'b0;
  logic        rst, Stall, Flush, InValid, RegWrite;
  logic [1:0]  Sel, AddrLow;
  logic [2:0]  Funct3;
  logic [4:0]  Rd;
  logic [31:0] mem, alu, pc4, imm;
  logic [127:0] in_data;

  assign in_data = {imm, pc4, alu, mem};

  always #5 clk = ~clk;

  logic        a_valid, a_rw, a_mis;
  logic [31:0] a_data;
  logic [4:0]  a_rd;
  logic        b_valid, b_rw, b_mis;
  logic [31:0] b_data;
  logic [4:0]  b_rd;
  logic        c_valid, c_rw, c_mis;
  logic [31:0] c_data;
  logic [4:0]  c_rd;

  wb_select_stage u_a (
    .clk(clk), .rst(rst), .Stall(Stall), .Flush(Flush), .InValid(InValid),
    .Sel(Sel), .InData(in_data), .Funct3(Funct3), .AddrLow(AddrLow),
    .Rd(Rd), .RegWrite(RegWrite),
    .OutValid(a_valid), .OutData(a_data), .OutRd(a_rd),
    .OutRegWrite(a_rw), .MisalignErr(a_mis)
  );

  wb_select_stage #(.NUM_SRC(3)) u_b (
    .clk(clk), .rst(rst), .Stall(Stall), .Flush(Flush), .InValid(InValid),
    .Sel(Sel), .InData(in_data[95:0]), .Funct3(Funct3), .AddrLow(AddrLow),
    .Rd(Rd), .RegWrite(RegWrite),
    .OutValid(b_valid), .OutData(b_data), .OutRd(b_rd),
    .OutRegWrite(b_rw), .MisalignErr(b_mis)
  );

  wb_select_stage #(.LOAD_EXT(0)) u_c (
    .clk(clk), .rst(rst), .Stall(Stall), .Flush(Flush), .InValid(InValid),
    .Sel(Sel), .InData(in_data), .Funct3(Funct3), .AddrLow(AddrLow),
    .Rd(Rd), .RegWrite(RegWrite),
    .OutValid(c_valid), .OutData(c_data), .OutRd(c_rd),
    .OutRegWrite(c_rw), .MisalignErr(c_mis)
  );

  typedef struct {
    logic        valid;
    logic [1:0]  sel;
    logic [31:0] mem;
    logic [2:0]  f3;
    logic [1:0]  addr;
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] exp_data;
    logic        exp_rw;
    logic        exp_mis;
  } vec_t;

  typedef struct {
    string       name;
    logic        valid;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        rw;
    logic        mis;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic check_a(input exp_t e);
    check({e.name, ".valid"}, 32'(a_valid), 32'(e.valid));
    check({e.name, ".data"},  a_data,       e.data);
    check({e.name, ".rd"},    32'(a_rd),    32'(e.rd));
    check({e.name, ".rw"},    32'(a_rw),    32'(e.rw));
    check({e.name, ".mis"},   32'(a_mis),   32'(e.mis));
  endtask

  task automatic drive(input vec_t v);
    InValid  = v.valid;
    Sel      = v.sel;
    mem      = v.mem;
    Funct3   = v.f3;
    AddrLow  = v.addr;
    Rd       = v.rd;
    RegWrite = v.rw;
  endtask

  task automatic apply(input string name, input vec_t v);
    exp_t e;
    @(negedge clk);
    drive(v);
    e.name  = name;
    e.valid = v.valid;
    e.data  = v.exp_data;
    e.rd    = v.rd;
    e.rw    = v.exp_rw;
    e.mis   = v.exp_mis;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL %s scoreboard empty actual=0 required=1", name);
    end else begin
      check_a(sb.pop_front());
    end
  endtask

  function automatic vec_t mk(input logic valid, input logic [1:0] sel, input logic [31:0] m,
                              input logic [2:0] f3, input logic [1:0] addr, input logic [4:0] rd,
                              input logic rw, input logic [31:0] d, input logic erw,
                              input logic emis);
    vec_t v;
    v.valid = valid; v.sel = sel; v.mem = m; v.f3 = f3; v.addr = addr;
    v.rd = rd; v.rw = rw; v.exp_data = d; v.exp_rw = erw; v.exp_mis = emis;
    return v;
  endfunction

  vec_t tbl[$];
  vec_t hold_v;
  exp_t hold_e;

  initial begin
    rst = 1'b1; Stall = 1'b0; Flush = 1'b0;
    alu = 32'h1234_5678; pc4 = 32'h0000_0104; imm = 32'hFFFF_F00D;
    drive(mk(1'b0, 2'd0, 32'h0, 3'b010, 2'd0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0));

    repeat (2) @(posedge clk);
    #1;
    hold_e = '{"reset", 1'b0, 32'h0, 5'd0, 1'b0, 1'b0};
    check_a(hold_e);

    @(negedge clk);
    rst = 1'b0;
    apply("pre_rst", mk(1'b1, 2'd2, 32'h0, 3'b010, 2'd0, 5'd7, 1'b1, 32'h0000_0104, 1'b1, 1'b0));
    // Asynchronous reset asserted mid-cycle while stalled.
    @(negedge clk);
    Stall = 1'b1;
    #2 rst = 1'b1;
    #1;
    hold_e = '{"rst_async", 1'b0, 32'h0, 5'd0, 1'b0, 1'b0};
    check_a(hold_e);
    @(posedge clk);
    #1;
    hold_e.name = "rst_held";
    check_a(hold_e);
    @(negedge clk);
    rst = 1'b0; Stall = 1'b0;
    apply("post_rst", mk(1'b1, 2'd1, 32'h0, 3'b010, 2'd0, 5'd5, 1'b1, 32'h1234_5678, 1'b1, 1'b0));

    tbl.push_back(mk(1, 0, 32'h80FF_7F01, 3'b000, 0, 5'd1, 1, 32'h0000_0001, 1, 0));
    tbl.push_back(mk(1, 0, 32'h80FF_7F01, 3'b000, 1, 5'd1, 1, 32'h0000_007F, 1, 0));
    tbl.push_back(mk(1, 0, 32'h80FF_7F01, 3'b000, 2, 5'd1, 1, 32'hFFFF_FFFF, 1, 0));
    tbl.push_back(mk(1, 0, 32'h80FF_7F01, 3'b000, 3, 5'd1, 1, 32'hFFFF_FF80, 1, 0));
    tbl.push_back(mk(1, 0, 32'h80FF_7F01, 3'b100, 0, 5'd2, 1, 32'h0000_0001, 1, 0));
    tbl.push_back(mk(1, 0, 32'h80FF_7F01, 3'b100, 1, 5'd2, 1, 32'h0000_007F, 1, 0));
    tbl.push_back(mk(1, 0, 32'h80FF_7F01, 3'b100, 2, 5'd2, 1, 32'h0000_00FF, 1, 0));
    tbl.push_back(mk(1, 0, 32'h80FF_7F01, 3'b100, 3, 5'd2, 1, 32'h0000_0080, 1, 0));
    tbl.push_back(mk(1, 0, 32'h8001_0000, 3'b001, 2, 5'd3, 1, 32'hFFFF_8001, 1, 0));
    tbl.push_back(mk(1, 0, 32'h8001_0000, 3'b001, 1, 5'd3, 1, 32'h0000_0000, 0, 1));
    tbl.push_back(mk(1, 0, 32'h8001_0000, 3'b010, 0, 5'd3, 1, 32'h8001_0000, 1, 0));
    tbl.push_back(mk(1, 0, 32'h80FF_7F01, 3'b101, 2, 5'd4, 1, 32'h0000_80FF, 1, 0));
    tbl.push_back(mk(1, 0, 32'h80FF_7F01, 3'b001, 0, 5'd4, 1, 32'h0000_7F01, 1, 0));
    tbl.push_back(mk(1, 0, 32'h80FF_7F01, 3'b101, 3, 5'd4, 1, 32'h0000_0000, 0, 1));
    tbl.push_back(mk(1, 0, 32'hDEAD_BEEF, 3'b010, 2, 5'd6, 1, 32'h0000_0000, 0, 1));
    tbl.push_back(mk(1, 0, 32'hDEAD_BEEF, 3'b011, 1, 5'd6, 1, 32'hDEAD_BEEF, 1, 0));
    tbl.push_back(mk(0, 0, 32'hDEAD_BEEF, 3'b010, 3, 5'd6, 1, 32'hDEAD_BEEF, 0, 0));
    tbl.push_back(mk(1, 1, 32'h0,         3'b010, 0, 5'd0, 1, 32'h1234_5678, 0, 0));
    tbl.push_back(mk(0, 2, 32'h0,         3'b010, 0, 5'd8, 1, 32'h0000_0104, 0, 0));
    tbl.push_back(mk(1, 3, 32'h0,         3'b000, 1, 5'd31, 1, 32'hFFFF_F00D, 1, 0));
    tbl.push_back(mk(1, 1, 32'h0,         3'b010, 0, 5'd9, 0, 32'h1234_5678, 0, 0));
    foreach (tbl[i]) apply($sformatf("vec%0d", i), tbl[i]);

    hold_v = mk(1, 0, 32'h80FF_7F01, 3'b000, 3, 5'd9, 1, 32'hFFFF_FF80, 1, 0);
    apply("stall_pre", hold_v);
    hold_e = '{"stall_hold", 1'b1, 32'hFFFF_FF80, 5'd9, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      Stall = 1'b1;
      drive(mk(1, 2'(i + 1), $urandom, 3'b001, 1, 5'(10 + i), 1, 32'h0, 0, 0));
      @(posedge clk);
      #1;
      check_a(hold_e);
    end
    @(negedge clk);
    Flush = 1'b1;
    @(posedge clk);
    #1;
    hold_e = '{"stall_flush", 1'b0, 32'hFFFF_FF80, 5'd9, 1'b0, 1'b0};
    check_a(hold_e);
    @(negedge clk);
    Stall = 1'b0; Flush = 1'b0;

    apply("mis_pre", mk(1, 0, 32'h8001_0000, 3'b001, 3, 5'd12, 1, 32'h0, 0, 1));
    @(negedge clk);
    Flush = 1'b1;
    @(posedge clk);
    #1;
    hold_e = '{"mis_flush", 1'b0, 32'h0, 5'd12, 1'b0, 1'b0};
    check_a(hold_e);
    @(negedge clk);
    Flush = 1'b0;

    @(negedge clk);
    drive(mk(1, 3, 32'h0, 3'b010, 0, 5'd13, 1, 32'h0, 0, 0));
    @(posedge clk);
    #1;
    check("nsrc3_sel3.data", b_data, 32'h0);
    check("nsrc3_sel3.valid", 32'(b_valid), 32'h1);
    @(negedge clk);
    drive(mk(1, 2, 32'h0, 3'b010, 0, 5'd13, 1, 32'h0, 0, 0));
    @(posedge clk);
    #1;
    check("nsrc3_sel2.data", b_data, 32'h0000_0104);

    @(negedge clk);
    drive(mk(1, 0, 32'h80FF_7F01, 3'b000, 1, 5'd14, 1, 32'h0, 0, 0));
    @(posedge clk);
    #1;
    check("noext_lb.data", c_data, 32'h80FF_7F01);
    check("noext_lb.mis", 32'(c_mis), 32'h0);
    check("noext_lb.rw", 32'(c_rw), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
